// File: rtl/pad_driver_if.sv
// Request channel into pad_driver: a valid/ready handshake carrying a 2-bit pad colour.
interface pad_driver_if;
  logic       req_valid;
  logic [1:0] req_color;
  logic       req_ready;

  modport master (output req_valid, output req_color, input  req_ready);
  modport slave  (input  req_valid, input  req_color, output req_ready);
endinterface

// File: rtl/pad_driver.sv
// Lamp/tone driver: lights one pad for ON_TIME cycles, then stays dark for GAP_TIME cycles.
// Optional macro PAD_DRIVER_TONE_EN adds the square-wave tone generator (tone tied 0 otherwise).
module pad_driver #(
  parameter int unsigned ON_TIME     = 25000000,
  parameter int unsigned GAP_TIME    = 5000000,
  parameter int unsigned TONE_HALF_0 = 60241,
  parameter int unsigned TONE_HALF_1 = 80645,
  parameter int unsigned TONE_HALF_2 = 99206,
  parameter int unsigned TONE_HALF_3 = 119617
) (
  input  logic         sysclk,
  input  logic         sysrst_n,
  pad_driver_if.slave  req_if,
  input  logic         abort,
  output logic [3:0]   led,
  output logic         tone,
  output logic         busy
);

  if (ON_TIME < 1 || TONE_HALF_0 < 1 || TONE_HALF_1 < 1 ||
      TONE_HALF_2 < 1 || TONE_HALF_3 < 1) begin : g_bad_param
    $error("pad_driver: ON_TIME and TONE_HALF_* must be at least 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_GAP} state_t;

  localparam logic [31:0] ON_LAST  = 32'(ON_TIME) - 32'd1;
  localparam logic [31:0] GAP_LAST = 32'(GAP_TIME) - 32'd1;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;
  logic [1:0]  r_color;
  logic [1:0]  w_color_nxt;
  logic [3:0]  r_led;
  logic [3:0]  w_led_nxt;
  logic        r_busy;
  logic        w_busy_nxt;
  logic        r_ready;
  logic        w_ready_nxt;
  logic        w_ready;
  logic        w_hs;

  // Abort in IDLE must block a same-cycle handshake, so ready is gated combinationally.
  assign w_ready          = r_ready & ~abort;
  assign w_hs             = req_if.req_valid & w_ready;
  assign req_if.req_ready = w_ready;
  assign w_color_nxt      = w_hs ? req_if.req_color : r_color;

  always_ff @(posedge sysclk) begin
    if (!sysrst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_color <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_color <= w_color_nxt;
      r_led   <= w_led_nxt;
      r_busy  <= w_busy_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 32'd1;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_hs) w_state_nxt = ST_ON;
      end
      ST_ON: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == ON_LAST) begin
          w_state_nxt = (GAP_TIME > 0) ? ST_GAP : ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      ST_GAP: begin
        if (abort || r_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in flops aligned with r_state.
  always_comb begin
    w_led_nxt   = '0;
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_ready_nxt = (w_state_nxt == ST_IDLE);
    if (w_state_nxt == ST_ON) w_led_nxt = 4'b0001 << w_color_nxt;
  end

  assign led  = r_led;
  assign busy = r_busy;

`ifdef PAD_DRIVER_TONE_EN
  logic [31:0] r_tcnt;
  logic        r_tone;
  logic [31:0] w_half_last;

  always_comb begin
    case (r_color)
      2'd0:    w_half_last = 32'(TONE_HALF_0) - 32'd1;
      2'd1:    w_half_last = 32'(TONE_HALF_1) - 32'd1;
      2'd2:    w_half_last = 32'(TONE_HALF_2) - 32'd1;
      default: w_half_last = 32'(TONE_HALF_3) - 32'd1;
    endcase
  end

  // Counting only while staying in ON makes every ON entry start from phase zero.
  always_ff @(posedge sysclk) begin
    if (!sysrst_n) begin
      r_tcnt <= '0;
      r_tone <= 1'b0;
    end else if (r_state != ST_ON || w_state_nxt != ST_ON) begin
      r_tcnt <= '0;
      r_tone <= 1'b0;
    end else if (r_tcnt == w_half_last) begin
      r_tcnt <= '0;
      r_tone <= ~r_tone;
    end else begin
      r_tcnt <= r_tcnt + 32'd1;
    end
  end

  assign tone = r_tone;
`else
  assign tone = 1'b0;
`endif

endmodule

// File: doc/pad_driver.md
PAD_DRIVER -- requirements
Module: pad_driver

Interface
REQ-001 Parameter ON_TIME, default 25000000, cycles a pad stays lit (0.5 s at 50 MHz); legal range >= 1.
REQ-002 Parameter GAP_TIME, default 5000000, dark cycles after each pad before the next request is accepted; 0 is legal.
REQ-003 Parameters TONE_HALF_0..TONE_HALF_3, defaults 60241, 80645, 99206, 119617: tone half-period in cycles per color (about 415/310/252/209 Hz); legal range >= 1.
REQ-004 sysclk  input  1  system clock (50 MHz); the block uses one clock only.
REQ-005 sysrst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  1  a pad-play request is present.
REQ-007 req_color  input  2  pad index 0..3, sampled on handshake.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 abort  input  1  terminates the current pad immediately.
REQ-010 led  output  4  one-hot pad lamp drive; bit i = pad i.
REQ-011 tone  output  1  square-wave speaker drive.
REQ-012 busy  output  1  high in ON or GAP.

Function
REQ-013 The FSM SHALL have three states: IDLE, ON and GAP; all outputs SHALL be registered.
REQ-014 IDLE: req_ready=1, led=0, tone=0, busy=0.
- Handshake = req_valid & req_ready at a rising edge.
- On handshake: latch req_color, clear the 32-bit cycle counter, enter ON.
REQ-015 ON: led = one-hot(latched color) and busy=1 for exactly ON_TIME consecutive cycles, starting the cycle after the handshake edge.
REQ-016 ON exit: to GAP when GAP_TIME>0; directly to IDLE when GAP_TIME==0.
REQ-017 GAP: led=0, tone=0, busy=1, req_ready=0 for exactly GAP_TIME cycles, then IDLE.
REQ-018 req_ready SHALL be 0 in ON and GAP; req_valid in those states is ignored (not queued).
REQ-019 Tone in ON:
- tone=0 in the first ON cycle.
- tone toggles every TONE_HALF_c cycles, where c is the latched color.
- The half-period counter restarts on each ON entry.
REQ-020 Tone in IDLE and GAP: forced to 0.
REQ-021 Counters SHALL be 32 bits unsigned and SHALL NOT wrap within any legal parameter value.
REQ-022 abort=1 in ON or GAP: next cycle in IDLE with led=0, tone=0, busy=0, req_ready=1.
REQ-023 abort=1 in IDLE together with req_valid=1: abort wins, req_ready=0 that cycle, no handshake.
REQ-024 req_color changes after the handshake SHALL NOT affect led or tone.
REQ-025 Back-to-back: with req_valid held high, the next handshake occurs in the first IDLE cycle after GAP; inter-pad dark time = GAP_TIME + 1 cycles.

Reset
REQ-026 sysrst_n=0 at a rising edge SHALL force IDLE, clear all counters and the latched color, and drive led=0, tone=0, busy=0, req_ready=0 on the following cycle.
REQ-027 req_ready SHALL return to 1 the first cycle after sysrst_n is sampled high.
REQ-028 Reset in ON or GAP SHALL abandon the pad with no further led activity.
REQ-029 No output SHALL be X after the first reset edge.

Configuration
REQ-030 Macro PAD_DRIVER_TONE_EN:
- Defined: tone generation is per REQ-019/020.
- Undefined: the tone generator and its counter are not compiled, and tone is tied to 0.
- All other behaviour is identical in both cases.

Verification (ON_TIME=10, GAP_TIME=4, TONE_HALF_0..3 = 2,3,4,5, PAD_DRIVER_TONE_EN defined unless noted)
REQ-031 Reset, then req_valid=1, color=2 for one cycle -> led=4'b0100 for exactly 10 cycles, then 4 cycles led=0 with busy=1, then req_ready=1.
REQ-032 Color 0 accepted -> tone sequence in ON is 0,0,1,1,0,0,1,1,0,0, then tone=0 in GAP.
REQ-033 req_valid held high with colors 1 then 3 -> led 4'b0010 for 10 cycles, 5 dark cycles, then led 4'b1000 for 10 cycles.
REQ-034 abort=1 in the 4th ON cycle -> next cycle led=0, busy=0, req_ready=1; abort together with req_valid in IDLE -> no handshake.
REQ-035 sysrst_n=0 during GAP -> next cycle all outputs 0; one cycle after release req_ready=1.
REQ-036 Build without PAD_DRIVER_TONE_EN and rerun REQ-032 -> tone constantly 0 and led timing unchanged.
